// File: rtl/pe_conv_stream_pkg.sv
// Shared defaults, FSM encoding and configuration check for the streaming
// K x K convolution processing element.
package pe_conv_stream_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned FRAC_W_DEF  = 8;
    localparam int unsigned ACC_W_DEF   = 40;
    localparam int unsigned K_MAX_DEF   = 5;
    localparam int unsigned ROW_MAX_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // A frame is accepted only if a full k x k window fits inside it.
    function automatic logic cfg_valid(
        input int unsigned k,
        input int unsigned cols,
        input int unsigned rows,
        input int unsigned k_max,
        input int unsigned row_max
    );
        return (k != 0) && (k <= k_max) && (k <= cols) && (k <= rows)
            && (cols <= row_max);
    endfunction

endpackage

// File: rtl/pe_conv_stream_line_fifo.sv
// Row delay lines: tap l returns the pixel seen (l+1) rows earlier in the
// same column, addressed by the column counter so the tap length equals cols.
module pe_conv_stream_line_fifo
    import pe_conv_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ROW_MAX = ROW_MAX_DEF,
    parameter int unsigned LINES   = K_MAX_DEF - 1
) (
    input  logic                        clk,
    input  logic                        en_i,
    input  logic [$clog2(ROW_MAX)-1:0]  addr_i,
    input  logic [DATA_W-1:0]           din_i,
    output logic [LINES*DATA_W-1:0]     taps_o
);

    logic [DATA_W-1:0] mem_q [LINES][ROW_MAX];

    always_comb begin
        taps_o = '0;
        for (int l = 0; l < int'(LINES); l++) begin
            taps_o[l*DATA_W +: DATA_W] = mem_q[l][addr_i];
        end
    end

    // Each line hands its old entry down to the next line on every accept.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0][addr_i] <= din_i;
            for (int l = 1; l < int'(LINES); l++) begin
                mem_q[l][addr_i] <= mem_q[l-1][addr_i];
            end
        end
    end

endmodule

// File: rtl/pe_conv_stream.sv
// Streaming K x K convolution PE: weight load, raster pixel stream, 3-stage
// multiply / adder-tree / shift-saturate pipeline with output backpressure.
module pe_conv_stream
    import pe_conv_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned FRAC_W  = FRAC_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned K_MAX   = K_MAX_DEF,
    parameter int unsigned ROW_MAX = ROW_MAX_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(K_MAX+1)-1:0]     cfg_k,
    input  logic [$clog2(ROW_MAX+1)-1:0]   cfg_cols,
    input  logic [$clog2(ROW_MAX+1)-1:0]   cfg_rows,
    input  logic                           flt_valid,
    input  logic [DATA_W-1:0]              flt_data,
    output logic                           flt_ready,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned KW    = $clog2(K_MAX + 1);
    localparam int unsigned CW    = $clog2(ROW_MAX + 1);
    localparam int unsigned AW    = $clog2(ROW_MAX);
    localparam int unsigned LINES = K_MAX - 1;
    localparam int unsigned PW    = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state_q, state_d;

    logic [KW-1:0] k_q;
    logic [CW-1:0] cols_q, rows_q;
    logic [KW-1:0] wr_q, wc_q;
    logic [CW-1:0] col_q, row_q;

    logic busy_q, flt_ready_q, err_q, err_d;

    logic signed [DATA_W-1:0] wgt_q  [K_MAX][K_MAX];
    logic signed [DATA_W-1:0] win_q  [K_MAX][K_MAX-1];
    logic signed [DATA_W-1:0] win_d  [K_MAX][K_MAX];
    logic signed [PW-1:0]     prod_d [K_MAX][K_MAX];
    logic signed [PW-1:0]     prod_q [K_MAX][K_MAX];

    logic                     s1_v_q, s2_v_q, out_valid_q;
    logic signed [ACC_W-1:0]  sum_d, sum_q, shr_c;
    logic [DATA_W-1:0]        sat_c, out_data_q;

    logic advance_c, pix_acc_c, flt_acc_c, start_c, cfg_bad_c;
    logic last_flt_c, last_pix_c, win_ok_c, drain_c;
    logic [KW-1:0] wsel_r_c, wsel_c_c;
    logic [LINES*DATA_W-1:0] taps_c;

    // Handshake and position decode
    assign advance_c  = !out_valid_q || out_ready;
    assign start_c    = (state_q == ST_IDLE) && start;
    assign cfg_bad_c  = !cfg_valid(32'(cfg_k), 32'(cfg_cols), 32'(cfg_rows),
                                   K_MAX, ROW_MAX);
    assign flt_acc_c  = flt_valid && flt_ready_q;
    assign pix_acc_c  = in_valid && (state_q == ST_RUN) && advance_c;
    assign last_flt_c = (wr_q == k_q - KW'(1)) && (wc_q == k_q - KW'(1));
    assign last_pix_c = (row_q == rows_q - CW'(1)) && (col_q == cols_q - CW'(1));
    assign win_ok_c   = (row_q >= CW'(k_q) - CW'(1)) && (col_q >= CW'(k_q) - CW'(1));
    assign drain_c    = (state_q == ST_FLUSH) && out_valid_q && out_ready
                        && !s1_v_q && !s2_v_q;

    // Weights are stored rotated by 180 degrees so they line up with the
    // newest-first window, leaving unused slots at the far corner as zero.
    assign wsel_r_c = k_q - KW'(1) - wr_q;
    assign wsel_c_c = k_q - KW'(1) - wc_q;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad_c) err_d   = 1'b1;
                    else           state_d = ST_LOAD;
                end
            end
            ST_LOAD:  if (flt_acc_c && last_flt_c) state_d = ST_RUN;
            ST_RUN:   if (pix_acc_c && last_pix_c) state_d = ST_FLUSH;
            ST_FLUSH: if (drain_c)                 state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            flt_ready_q <= 1'b0;
            err_q       <= 1'b0;
            k_q         <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE);
            flt_ready_q <= (state_d == ST_LOAD);
            err_q       <= err_d;
            if (start_c) begin
                k_q    <= cfg_k;
                cols_q <= cfg_cols;
                rows_q <= cfg_rows;
                wr_q   <= '0;
                wc_q   <= '0;
                col_q  <= '0;
                row_q  <= '0;
            end
            if (flt_acc_c) begin
                if (wc_q == k_q - KW'(1)) begin
                    wc_q <= '0;
                    wr_q <= wr_q + KW'(1);
                end else begin
                    wc_q <= wc_q + KW'(1);
                end
            end
            if (pix_acc_c) begin
                if (col_q == cols_q - CW'(1)) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Weight register file; cleared on every start so k < K_MAX leaves zeros.
    always_ff @(posedge clk) begin
        for (int d = 0; d < int'(K_MAX); d++) begin
            for (int e = 0; e < int'(K_MAX); e++) begin
                if (start_c) begin
                    wgt_q[d][e] <= '0;
                end else if (flt_acc_c && (wsel_r_c == KW'(d)) && (wsel_c_c == KW'(e))) begin
                    wgt_q[d][e] <= $signed(flt_data);
                end
            end
        end
    end

    pe_conv_stream_line_fifo #(
        .DATA_W  (DATA_W),
        .ROW_MAX (ROW_MAX),
        .LINES   (LINES)
    ) u_line_fifo (
        .clk    (clk),
        .en_i   (pix_acc_c),
        .addr_i (col_q[AW-1:0]),
        .din_i  (in_data),
        .taps_o (taps_c)
    );

    // Stage 1: window shift (row d = d rows back, col e = e columns back) and multiply.
    always_comb begin
        win_d[0][0] = $signed(in_data);
        for (int d = 1; d < int'(K_MAX); d++) begin
            win_d[d][0] = $signed(taps_c[(d-1)*DATA_W +: DATA_W]);
        end
        for (int d = 0; d < int'(K_MAX); d++) begin
            for (int e = 1; e < int'(K_MAX); e++) begin
                win_d[d][e] = win_q[d][e-1];
            end
        end
        for (int d = 0; d < int'(K_MAX); d++) begin
            for (int e = 0; e < int'(K_MAX); e++) begin
                prod_d[d][e] = PW'(win_d[d][e]) * PW'(wgt_q[d][e]);
            end
        end
    end

    // Stage 2: adder tree over sign-extended products.
    always_comb begin
        sum_d = '0;
        for (int d = 0; d < int'(K_MAX); d++) begin
            for (int e = 0; e < int'(K_MAX); e++) begin
                sum_d = sum_d + ACC_W'(prod_q[d][e]);
            end
        end
    end

    // Stage 3: drop fraction bits (floor) and clamp to the output range.
    always_comb begin
        shr_c = sum_q >>> FRAC_W;
        if (shr_c > SAT_HI) begin
            sat_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shr_c < SAT_LO) begin
            sat_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_c = shr_c[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc_c) begin
            prod_q <= prod_d;
            for (int d = 0; d < int'(K_MAX); d++) begin
                for (int e = 0; e < int'(K_MAX) - 1; e++) begin
                    win_q[d][e] <= win_d[d][e];
                end
            end
        end
        if (advance_c && s1_v_q) begin
            sum_q <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (advance_c) begin
            s1_v_q      <= pix_acc_c && win_ok_c;
            s2_v_q      <= s1_v_q;
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_data_q <= sat_c;
            end
        end
    end

    assign flt_ready = flt_ready_q;
    assign in_ready  = (state_q == ST_RUN) && advance_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = drain_c;
    assign err       = err_q;

endmodule

// File: tb/tb_pe_conv_stream.sv
// Directed bench for pe_conv_stream: frame runs against a direct-form
// convolution model, hand tables for key frames and rejected configurations.
module tb_pe_conv_stream;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  cfg_k;
    logic [9:0]  cfg_cols, cfg_rows;
    logic        flt_valid, flt_ready;
    logic [15:0] flt_data;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    logic signed [15:0] img [0:63];
    logic signed [15:0] wts [0:24];
    logic [15:0]        rx  [0:63];

    typedef struct {
        int k;
        int cols;
        int rows;
        bit exp_err;
    } cfg_vec_t;

    always #5 clk = ~clk;

    pe_conv_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_k     (cfg_k),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .flt_valid (flt_valid),
        .flt_data  (flt_data),
        .flt_ready (flt_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Runs one frame from the current negedge; results land in rx[].
    task automatic run_frame(input int k, input int cols, input int rows,
                             input bit bp, input bit chk_lat);
        int nexp, n, fi, pi, oi, cyc, dn;
        logic [15:0] expv [0:63];
        int acc_cyc [0:63];
        logic held_v;
        logic [15:0] held_d;
        nexp = (rows - k + 1) * (cols - k + 1);
        n = 0;
        for (int i = 0; i <= rows - k; i++) begin
            for (int j = 0; j <= cols - k; j++) begin
                longint acc;
                acc = 0;
                for (int r = 0; r < k; r++)
                    for (int c = 0; c < k; c++)
                        acc += longint'(wts[r*k+c]) * longint'(img[(i+r)*cols + j + c]);
                acc = acc >>> 8;
                if (acc > 32767) acc = 32767;
                else if (acc < -32768) acc = -32768;
                expv[n] = 16'(acc);
                n++;
            end
        end
        cfg_k = 3'(k); cfg_cols = 10'(cols); cfg_rows = 10'(rows); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        fi = 0; pi = 0; oi = 0; cyc = 0; dn = 0; held_v = 1'b0; held_d = '0;
        while (oi < nexp && cyc < 4000) begin
            flt_valid = (fi < k*k);
            flt_data  = wts[fi < 25 ? fi : 0];
            in_valid  = (pi < cols*rows);
            in_data   = img[pi < 64 ? pi : 0];
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_d);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (flt_valid && flt_ready) fi++;
            if (in_valid && in_ready) begin
                acc_cyc[pi] = cyc;
                pi++;
            end
            if (out_valid && out_ready) begin
                chk("out_data", out_data, expv[oi]);
                rx[oi] = out_data;
                if (chk_lat) chk("latency", cyc - acc_cyc[oi], 3);
                oi++;
            end
            if (done) begin
                dn++;
                chk("done_on_last", oi, nexp);
            end
            cyc++;
            @(negedge clk);
        end
        chk("out_count", oi, nexp);
        flt_valid = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (done) dn++;
            chk("idle_flt_ready", flt_ready, 0);
            chk("idle_in_ready", in_ready, 0);
            @(negedge clk);
        end
        flt_valid = 1'b0; in_valid = 1'b0;
        chk("done_once", dn, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        cfg_vec_t   bad_cfg [5];
        logic [15:0] exp1   [9];
        int fi, pi;

        bad_cfg[0] = '{k: 4, cols: 3,   rows: 5, exp_err: 1'b1};
        bad_cfg[1] = '{k: 6, cols: 8,   rows: 8, exp_err: 1'b1};
        bad_cfg[2] = '{k: 0, cols: 4,   rows: 4, exp_err: 1'b1};
        bad_cfg[3] = '{k: 3, cols: 3,   rows: 2, exp_err: 1'b1};
        bad_cfg[4] = '{k: 3, cols: 600, rows: 4, exp_err: 1'b1};
        exp1 = '{16'h3600, 16'h3F00, 16'h4800, 16'h6300, 16'h6C00,
                 16'h7500, 16'h7FFF, 16'h7FFF, 16'h7FFF};

        rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_cols = '0; cfg_rows = '0;
        flt_valid = 1'b0; flt_data = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flt_ready", flt_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // k=3 on 5x5 ramp with unity weights
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) img[i*5+j] = 16'((5*i + j) * 256);
        for (int i = 0; i < 9; i++) wts[i] = 16'h0100;
        run_frame(3, 5, 5, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) chk("ramp_table", rx[i], exp1[i]);

        // k=1 identity, 4 columns x 3 rows, exact latency
        for (int i = 0; i < 12; i++) img[i] = 16'(i * 1234 - 7000);
        wts[0] = 16'h0100;
        run_frame(1, 4, 3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) chk("k1_identity", rx[i], $unsigned(img[i]));

        // k=5 on 8x6 random data with random output stalls
        for (int i = 0; i < 48; i++) img[i] = 16'($urandom_range(0, 4095)) - 16'sd2048;
        for (int i = 0; i < 25; i++) wts[i] = 16'($urandom_range(0, 511)) - 16'sd256;
        run_frame(5, 8, 6, 1'b1, 1'b0);

        // Saturation both ways
        for (int i = 0; i < 25; i++) img[i] = 16'h7FFF;
        for (int i = 0; i < 9; i++) wts[i] = 16'h7FFF;
        run_frame(3, 5, 5, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) chk("sat_pos", rx[i], 16'h7FFF);
        for (int i = 0; i < 9; i++) wts[i] = 16'h8000;
        run_frame(3, 5, 5, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) chk("sat_neg", rx[i], 16'h8000);

        // Rejected configurations
        for (int v = 0; v < 5; v++) begin
            cfg_k = 3'(bad_cfg[v].k); cfg_cols = 10'(bad_cfg[v].cols);
            cfg_rows = 10'(bad_cfg[v].rows); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("cfg_err", err, bad_cfg[v].exp_err);
            chk("cfg_busy", busy, 0);
            chk("cfg_done", done, 0);
            @(negedge clk);
            chk("cfg_err_pulse", err, 0);
        end

        // Reset in the middle of RUN with results in flight
        cfg_k = 3'd3; cfg_cols = 10'd5; cfg_rows = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fi = 0; pi = 0; out_ready = 1'b1;
        for (int c = 0; c < 60 && pi < 17; c++) begin
            flt_valid = (fi < 9); flt_data = 16'h0100;
            in_valid = 1'b1; in_data = 16'h0100;
            #1;
            if (flt_valid && flt_ready) fi++;
            if (in_valid && in_ready) pi++;
            @(negedge clk);
        end
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 16'h0900);
        rst = 1'b1; flt_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_flt_ready", flt_ready, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);

        // Clean 3x3 frame after the reset
        for (int i = 0; i < 9; i++) img[i] = 16'((i + 1) * 16'sh0080 - 16'sh0200);
        for (int i = 0; i < 9; i++) wts[i] = 16'(i * 40 - 150);
        run_frame(3, 3, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
